// File: rtl/uc_booth.sv
// Control unit for an N-iteration signed Booth multiplier; one-hot Moore FSM.
// Optional feature: define UC_FIN_STICKY_EN to hold DONE/fin while start stays high.
module uc_booth #(
    parameter int unsigned N = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic q0,
    input  logic q_menos1,
    output logic Carga_A,
    output logic Resta,
    output logic Carga_QM,
    output logic Reset_A,
    output logic Desplaza_AQ,
    output logic busy,
    output logic fin
);

    localparam int unsigned CntW = $clog2(N + 1);

    localparam int unsigned IdxIdle  = 0;
    localparam int unsigned IdxLoad  = 1;
    localparam int unsigned IdxEval  = 2;
    localparam int unsigned IdxSuma  = 3;
    localparam int unsigned IdxResta = 4;
    localparam int unsigned IdxShift = 5;
    localparam int unsigned IdxDone  = 6;

    typedef enum logic [6:0] {
        StIdle  = 7'b000_0001,
        StLoad  = 7'b000_0010,
        StEval  = 7'b000_0100,
        StSuma  = 7'b000_1000,
        StResta = 7'b001_0000,
        StShift = 7'b010_0000,
        StDone  = 7'b100_0000
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StLoad;
            end
            StLoad: begin
                cnt_d   = CntW'(N);
                state_d = StEval;
            end
            StEval: begin
                unique case ({q0, q_menos1})
                    2'b10:   state_d = StResta;
                    2'b01:   state_d = StSuma;
                    default: state_d = StShift;
                endcase
            end
            StSuma:  state_d = StShift;
            StResta: state_d = StShift;
            StShift: begin
                cnt_d   = cnt_q - CntW'(1);
                state_d = (cnt_q == CntW'(1)) ? StDone : StEval;
            end
            StDone: begin
`ifdef UC_FIN_STICKY_EN
                if (!start) state_d = StIdle;
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // Strobes come straight off the one-hot flops so they cannot glitch.
    assign Carga_QM    = state_q[IdxLoad];
    assign Reset_A     = state_q[IdxLoad];
    assign Carga_A     = state_q[IdxSuma] | state_q[IdxResta];
    assign Resta       = state_q[IdxResta];
    assign Desplaza_AQ = state_q[IdxShift];
    assign fin         = state_q[IdxDone];
    assign busy        = ~(state_q[IdxIdle] | state_q[IdxDone]);

    logic unused_eval;
    assign unused_eval = state_q[IdxEval];

endmodule

// File: tb/tb_uc_booth.sv
// Bench for uc_booth: behavioural Booth datapath plus a reference strobe-sequence model.
module tb_uc_booth;

    logic clk = 1'b0;
    logic reset, start, q0, q_menos1;
    logic Carga_A, Resta, Carga_QM, Reset_A, Desplaza_AQ, busy, fin;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [6:0] CIdle  = 7'b0000000;
    localparam logic [6:0] CLoad  = 7'b0000111;
    localparam logic [6:0] CEval  = 7'b0000001;
    localparam logic [6:0] CSuma  = 7'b0010001;
    localparam logic [6:0] CResta = 7'b0011001;
    localparam logic [6:0] CShift = 7'b0100001;
    localparam logic [6:0] CDone  = 7'b1000000;

    uc_booth #(.N(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .q0         (q0),
        .q_menos1   (q_menos1),
        .Carga_A    (Carga_A),
        .Resta      (Resta),
        .Carga_QM   (Carga_QM),
        .Reset_A    (Reset_A),
        .Desplaza_AQ(Desplaza_AQ),
        .busy       (busy),
        .fin        (fin)
    );

    always #5 clk = ~clk;

    logic [6:0] code;
    assign code = {fin, Desplaza_AQ, Carga_A, Resta, Carga_QM, Reset_A, busy};

    // Datapath stand-in; A has a guard bit so A-M cannot overflow for M = -4.
    logic [2:0] m_in, q_in;
    logic [3:0] a_q;
    logic [2:0] qr_q, m_q;
    logic       q1_q;
    always @(posedge clk) begin
        if (Carga_QM) begin
            m_q  <= m_in;
            qr_q <= q_in;
            q1_q <= 1'b0;
        end
        if (Reset_A) a_q <= 4'd0;
        if (Carga_A) a_q <= Resta ? a_q - {m_q[2], m_q} : a_q + {m_q[2], m_q};
        if (Desplaza_AQ) begin
            a_q  <= {a_q[3], a_q[3:1]};
            qr_q <= {a_q[0], qr_q[2:1]};
            q1_q <= qr_q[0];
        end
    end
    assign q0       = qr_q[0];
    assign q_menos1 = q1_q;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One complete multiplication; checks every cycle's strobes, fin edge and product.
    task automatic run_op(input logic [2:0] m, input logic [2:0] q, input bit poke);
        logic [6:0] seq[$];
        int k, fin_edge, prod;
        logic prev;
        prev = 1'b0;
        k = 0;
        seq.push_back(CLoad);
        for (int i = 0; i < 3; i++) begin
            seq.push_back(CEval);
            if (q[i] && !prev) seq.push_back(CResta);
            if (!q[i] && prev) seq.push_back(CSuma);
            if (q[i] != prev) k++;
            seq.push_back(CShift);
            prev = q[i];
        end
        seq.push_back(CDone);
        prod = int'($signed(m)) * int'($signed(q));

        m_in  = m;
        q_in  = q;
        start = 1'b1;
        fin_edge = -1;
        for (int j = 0; j < seq.size(); j++) begin
            @(posedge clk);
            #1;
            if (j == 0) start = 1'b0;
            chk_eq("seq", 32'(code), 32'(seq[j]));
            if (fin && fin_edge < 0) fin_edge = j;
            if (poke && j == 2) start = 1'b1;
            if (poke && j == 3) start = 1'b0;
        end
        chk_eq("fin_edge", fin_edge, 7 + k);
        chk_eq("result", 32'({a_q[2:0], qr_q}), 32'(prod[5:0]));
        @(posedge clk);
        #1;
        chk_eq("back_idle", 32'(code), 32'(CIdle));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        m_in  = 3'd0;
        q_in  = 3'd0;
        #2;
        chk_eq("reset_async", 32'(code), 32'(CIdle));
        repeat (2) @(posedge clk);
        #1;
        chk_eq("reset_held", 32'(code), 32'(CIdle));
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk_eq("idle_no_start", 32'(code), 32'(CIdle));

        run_op(3'd3, 3'b110, 1'b0);   // 3 * -2 = -6
        run_op(3'b100, 3'b101, 1'b0); // -4 * -3 = 12
        run_op(3'd2, 3'd0, 1'b0);     // no add/sub at all
        run_op(3'd3, 3'b011, 1'b1);   // start poked while busy

        // Asynchronous reset caught in SUMA: Q=101 gives RESTA then SUMA at edge 5.
        m_in  = 3'd1;
        q_in  = 3'b101;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk_eq("in_suma", 32'(code), 32'(CSuma));
        #2;
        reset = 1'b1;
        #1;
        chk_eq("reset_mid_suma", 32'(code), 32'(CIdle));
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk_eq("idle_after_reset", 32'(code), 32'(CIdle));
        run_op(3'd2, 3'b111, 1'b0);

        for (int r = 0; r < 40; r++) begin
            run_op(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), bit'($urandom_range(0, 1)));
        end

        // start held for 15 edges; Q=110 puts DONE at edge 8.
        m_in  = 3'd3;
        q_in  = 3'b110;
        start = 1'b1;
        for (int j = 0; j < 15; j++) begin
            @(posedge clk);
            #1;
`ifdef UC_FIN_STICKY_EN
            if (j >= 8) chk_eq("fin_sticky", 32'(fin), 32'd1);
`else
            if (j == 8) chk_eq("fin_pulse", 32'(code), 32'(CDone));
            if (j == 9) chk_eq("fin_one_cycle", 32'(code), 32'(CIdle));
            if (j == 10) chk_eq("restart_load", 32'(code), 32'(CLoad));
`endif
        end
        start = 1'b0;
`ifdef UC_FIN_STICKY_EN
        @(posedge clk);
        #1;
        chk_eq("sticky_release", 32'(code), 32'(CIdle));
`else
        begin
            int waited;
            waited = 0;
            while (code != CIdle && waited < 20) begin
                @(posedge clk);
                #1;
                waited++;
            end
            chk_eq("drain_timeout", 32'(code), 32'(CIdle));
        end
`endif
        run_op(3'b101, 3'b010, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
